// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Key-event channel from the PS/2 receiver to the keyboard matrix logic.
interface ps2_kbd_rx_if;
  // An event transfers on a clk_sys edge where key_valid && key_ready. The
  // source holds key_code/flags stable while key_valid is high. Without the
  // event FIFO, key_valid is a one-cycle strobe and key_ready is ignored.
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       key_ready;

  modport master (
    output key_valid, key_code, key_extended, key_released,
    input  key_ready
  );

  modport slave (
    input  key_valid, key_code, key_extended, key_released,
    output key_ready
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// Four-entry event FIFO; a push into a full FIFO is dropped unless a pop happens in the same cycle.
module ps2_rx_fifo
  import ps2_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       push,
  input  ps2_event_t din,
  input  logic       pop,
  output logic       valid,
  output ps2_event_t dout,
  output logic       drop
);

  ps2_event_t mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       full;
  logic       pop_ok;
  logic       push_ok;

  assign valid   = (wr_ptr != rd_ptr) || full;
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
      if (push_ok && !pop_ok && ((wr_ptr + 2'd1) == rd_ptr)) full <= 1'b1;
      else if (pop_ok && !push_ok) full <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix folding, key events.
// Define PS2_RX_FIFO_EN for a 4-entry event FIFO with key_valid/key_ready flow control.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter logic [15:0] TIMEOUT     = 16'd50000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         ps2_kbd_clk,
  input  logic         ps2_kbd_data,
  ps2_kbd_rx_if.master kbd,
  output logic         frame_err,
  output logic         overflow,
  output ps2_state_e   rx_state
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   data_s;
  logic                   fe;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_kbd_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_kbd_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign data_s = data_sync[SYNC_STAGES-1];
  assign fe     = clk_prev && !clk_sync[SYNC_STAGES-1];

  ps2_state_e  state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic        par_acc, par_n;
  logic        err_mark, err_n;
  logic [15:0] to_cnt, to_cnt_n;
  logic        byte_stb, byte_stb_n;
  logic        err_stb, err_stb_n;
  logic        to_stb, to_stb_n;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b1;
      err_mark <= 1'b0;
      to_cnt   <= '0;
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
      to_stb   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_acc  <= par_n;
      err_mark <= err_n;
      to_cnt   <= to_cnt_n;
      byte_stb <= byte_stb_n;
      err_stb  <= err_stb_n;
      to_stb   <= to_stb_n;
    end
  end

  // A falling edge takes priority over timeout expiry in the same cycle.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_n      = par_acc;
    err_n      = err_mark;
    to_cnt_n   = to_cnt;
    byte_stb_n = 1'b0;
    err_stb_n  = 1'b0;
    to_stb_n   = 1'b0;
    if (fe) begin
      to_cnt_n = '0;
      unique case (state)
        IDLE: begin
          if (!data_s) begin
            state_n   = DATA;
            bit_cnt_n = '0;
            par_n     = 1'b1;
            err_n     = 1'b0;
          end else begin
            err_stb_n = 1'b1;
          end
        end
        DATA: begin
          shreg_n   = {data_s, shreg[7:1]};
          par_n     = par_acc ^ data_s;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) state_n = PAR;
        end
        PAR: begin
          if (data_s != par_acc) err_n = 1'b1;
          state_n = STOP;
        end
        STOP: begin
          if (!data_s || err_mark) err_stb_n  = 1'b1;
          else                     byte_stb_n = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state == IDLE) begin
      to_cnt_n = '0;
    end else if (to_cnt == 16'(TIMEOUT - 16'd1)) begin
      state_n  = IDLE;
      to_cnt_n = '0;
      to_stb_n = 1'b1;
    end else begin
      to_cnt_n = to_cnt + 16'd1;
    end
  end

  assign rx_state  = state;
  assign frame_err = err_stb | to_stb;

  // Timeouts deliberately leave the pending prefixes intact.
  logic       ext_pend, rel_pend;
  logic       is_prefix;
  logic       ev_fire;
  ps2_event_t ev;

  assign is_prefix = (shreg == PS2_PREFIX_EXT) || (shreg == PS2_PREFIX_REL);
  assign ev_fire   = byte_stb && !is_prefix;
  assign ev        = '{ext: ext_pend, rel: rel_pend, code: shreg};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_pend <= 1'b0;
      rel_pend <= 1'b0;
    end else if (err_stb) begin
      ext_pend <= 1'b0;
      rel_pend <= 1'b0;
    end else if (byte_stb) begin
      if (shreg == PS2_PREFIX_EXT)      ext_pend <= 1'b1;
      else if (shreg == PS2_PREFIX_REL) rel_pend <= 1'b1;
      else begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end
    end
  end

`ifdef PS2_RX_FIFO_EN
  ps2_event_t head;
  logic       head_valid;
  logic       drop;

  ps2_rx_fifo u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (ev_fire),
    .din     (ev),
    .pop     (kbd.key_ready),
    .valid   (head_valid),
    .dout    (head),
    .drop    (drop)
  );

  assign kbd.key_valid    = head_valid;
  assign kbd.key_code     = head.code;
  assign kbd.key_extended = head.ext;
  assign kbd.key_released = head.rel;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)  overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`else
  logic       valid_q;
  ps2_event_t ev_q;
  wire        unused_key_ready = kbd.key_ready;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      ev_q     <= '0;
      overflow <= 1'b0;
    end else begin
      valid_q <= ev_fire;
      if (ev_fire) ev_q <= ev;
      if (ev_fire && valid_q) overflow <= 1'b1;
    end
  end

  assign kbd.key_valid    = valid_q;
  assign kbd.key_code     = ev_q.code;
  assign kbd.key_extended = ev_q.ext;
  assign kbd.key_released = ev_q.rel;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames, prefixes, errors, timeout, reset and the optional FIFO.
module tb_ps2_kbd_rx;
  import ps2_pkg::*;

  localparam logic [15:0] TO = 16'd300;

  logic       clk_sys      = 1'b0;
  logic       reset_n      = 1'b0;
  logic       ps2_kbd_clk  = 1'b1;
  logic       ps2_kbd_data = 1'b1;
  logic       frame_err;
  logic       overflow;
  ps2_state_e rx_state;

  ps2_kbd_rx_if kbd ();

  ps2_kbd_rx #(.TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .kbd          (kbd),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .rx_state     (rx_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;

  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int         obs_cyc_q[$];
  int         err_cyc_q[$];

  // event monitor, sampled on the falling clk_sys edge
  always @(negedge clk_sys) begin
    if (reset_n && mon_en) begin
      if (kbd.key_valid) begin
        obs_q.push_back({kbd.key_extended, kbd.key_released, kbd.key_code});
        obs_cyc_q.push_back(cyc);
      end
      if (frame_err) err_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic clear_obs();
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
    err_cyc_q.delete();
  endtask

  task automatic ps2_bit(input logic b, output int fe_cyc);
    @(negedge clk_sys);
    ps2_kbd_data = b;
    repeat (5) @(negedge clk_sys);
    ps2_kbd_clk = 1'b0;
    fe_cyc = cyc;
    repeat (10) @(negedge clk_sys);
    ps2_kbd_clk = 1'b1;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, output int stop_cyc);
    int   c;
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0, c);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], c);
    ps2_bit(p, c);
    ps2_bit(1'b1, stop_cyc);
    repeat (8) @(negedge clk_sys);
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({kbd.key_valid, kbd.key_code, kbd.key_extended, kbd.key_released, frame_err, overflow} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {kbd.key_valid, kbd.key_code, kbd.key_extended, kbd.key_released, frame_err, overflow});
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    checks++;
    if (rx_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", rx_state, IDLE);
    end
    checks++;
    if (kbd.key_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: key_valid=%b frame_err=%b, expected 0 0", kbd.key_valid, frame_err);
    end
  endtask

  task automatic test_make_1c();
    int stop_c;
    clear_obs();
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, stop_c);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL make_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL make_event: got %h, expected %h", obs_q[0], exp_q[0]);
      end
      checks++;
      if (obs_cyc_q[0] - stop_c != 4) begin
        errors++;
        $display("FAIL make_latency: got %0d cycles, expected 4", obs_cyc_q[0] - stop_c);
      end
    end
    checks++;
    if (err_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL make_no_err: got %0d frame errors, expected 0", err_cyc_q.size());
    end
`ifndef PS2_RX_FIFO_EN
    checks++;
    if (kbd.key_code !== 8'h1C) begin
      errors++;
      $display("FAIL make_hold: got %h, expected 1c", kbd.key_code);
    end
`endif
  endtask

  task automatic test_ext_rel();
    int c;
    clear_obs();
    exp_q.push_back({2'b11, 8'h75});
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'hE0, 1'b0, c);
    send_frame(8'hF0, 1'b0, c);
    send_frame(8'h75, 1'b0, c);
    send_frame(8'h1C, 1'b0, c);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL extrel_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL extrel_ev%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_parity_err();
    int c;
    clear_obs();
    send_frame(8'h1C, 1'b1, c);
    checks++;
    if (err_cyc_q.size() != 1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL parity_err: got %0d errors / %0d events, expected 1 / 0", err_cyc_q.size(), obs_q.size());
    end
    clear_obs();
    exp_q.push_back({2'b01, 8'h29});
    send_frame(8'hF0, 1'b0, c);
    send_frame(8'h29, 1'b0, c);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL parity_recover: got %0d events (first %h), expected 1 (%h)",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 10'h0, exp_q[0]);
    end
  endtask

  task automatic test_bad_start();
    int c;
    clear_obs();
    ps2_bit(1'b1, c);
    repeat (8) @(negedge clk_sys);
    checks++;
    if (err_cyc_q.size() != 1 || obs_q.size() != 0 || rx_state !== IDLE) begin
      errors++;
      $display("FAIL bad_start: got %0d errors / %0d events / state %0d, expected 1 / 0 / 0",
               err_cyc_q.size(), obs_q.size(), rx_state);
    end
  endtask

  task automatic test_timeout();
    int c, last_fe;
    clear_obs();
    send_frame(8'hF0, 1'b0, c);
    ps2_bit(1'b0, c);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1, last_fe);
    checks++;
    if (rx_state !== DATA) begin
      errors++;
      $display("FAIL timeout_mid_state: got %0d, expected %0d", rx_state, DATA);
    end
    while (err_cyc_q.size() == 0 && cyc < last_fe + 2 * int'(TO)) @(negedge clk_sys);
    checks++;
    if (err_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_err: got %0d frame errors, expected 1", err_cyc_q.size());
    end else begin
      checks++;
      if (err_cyc_q[0] < last_fe + int'(TO) || err_cyc_q[0] > last_fe + int'(TO) + 4) begin
        errors++;
        $display("FAIL timeout_time: got cycle %0d, expected %0d..%0d",
                 err_cyc_q[0] - last_fe, TO, int'(TO) + 4);
      end
    end
    repeat (2) @(negedge clk_sys);
    checks++;
    if (rx_state !== IDLE) begin
      errors++;
      $display("FAIL timeout_state: got %0d, expected %0d", rx_state, IDLE);
    end
    clear_obs();
    exp_q.push_back({2'b01, 8'h29});
    send_frame(8'h29, 1'b0, c);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL timeout_recover: got %0d events (first %h), expected 1 (%h)",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 10'h0, exp_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    clear_obs();
    send_frame(8'hF0, 1'b0, c);
    ps2_bit(1'b0, c);
    ps2_bit(1'b0, c);
    ps2_bit(1'b1, c);
    ps2_bit(1'b0, c);
    ps2_bit(1'b1, c);
    ps2_kbd_data = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({kbd.key_valid, kbd.key_code, kbd.key_extended, kbd.key_released, frame_err, overflow} !== 13'd0
        || rx_state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b state %0d, expected zeros state 0",
               {kbd.key_valid, kbd.key_code, kbd.key_extended, kbd.key_released, frame_err, overflow}, rx_state);
    end
    checks++;
    if (dut.clk_sync !== 2'b11 || dut.data_sync !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_sync: got clk %b data %b, expected 11 11", dut.clk_sync, dut.data_sync);
    end
    repeat (3) @(negedge clk_sys);
    ps2_kbd_data = 1'b1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    clear_obs();
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, c);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL reset_mid_recover: got %0d events (first %h), expected 1 (%h)",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 10'h0, exp_q[0]);
    end
  endtask

`ifdef PS2_RX_FIFO_EN
  task automatic test_fifo();
    int         c;
    logic [7:0] codes [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    mon_en = 1'b0;
    kbd.key_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(codes[i], 1'b0, c);
    checks++;
    if (overflow !== 1'b0 || kbd.key_valid !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full: overflow=%b key_valid=%b, expected 0 1", overflow, kbd.key_valid);
    end
    send_frame(codes[4], 1'b0, c);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL fifo_overflow: got %b, expected 1", overflow);
    end
    @(negedge clk_sys);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (kbd.key_valid !== 1'b1 || kbd.key_code !== codes[i]) begin
        errors++;
        $display("FAIL fifo_drain%0d: valid=%b code=%h, expected 1 %h", i, kbd.key_valid, kbd.key_code, codes[i]);
      end
      kbd.key_ready = 1'b1;
      @(negedge clk_sys);
    end
    checks++;
    if (kbd.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL fifo_empty: key_valid=%b, expected 0", kbd.key_valid);
    end
    mon_en = 1'b1;
  endtask
`endif

  initial begin
    kbd.key_ready = 1'b1;
    test_reset();
    test_make_1c();
    test_ext_rel();
    test_parity_err();
    test_bad_start();
    test_timeout();
    test_reset_mid();
`ifdef PS2_RX_FIFO_EN
    test_fifo();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
